// File: rtl/flop_pipe.sv
// flop_pipe: DEPTH-stage, WIDTH-bit elastic register pipeline.
//
// Each stage holds one word plus a valid bit. A stage accepts from upstream
// whenever it is empty or the stage ahead of it is able to move, so bubbles
// are squeezed out under backpressure and full throughput is kept when the
// downstream is ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active-low; clears valids, loads RESET_VAL
//   in_valid   upstream presents in_data
//   in_ready   pipe accepts in_data this cycle
//   in_data    input word
//   out_valid  last stage holds a valid word
//   out_ready  downstream accepts out_data this cycle
//   out_data   last-stage data register (driven unconditionally)
//   flush      synchronous clear of every valid bit (data left untouched)
//   count      number of valid stages, 0..DEPTH
module flop_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_vld;
  logic [WIDTH-1:0] up_data [DEPTH];
  logic [DEPTH-1:0] mask;
  logic [CNT_W-1:0] cnt_q;
  logic             in_xfer;
  logic             out_xfer;

  // Stage i can load when the downstream accepts, or when at least one stage
  // from i to the output is empty. This is the unrolled form of the
  // r[i] = ~v[i] | r[i+1] chain, written without a self-referencing vector.
  always_comb begin
    rdy  = '0;
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mask   = {DEPTH{1'b1}} << i;
      rdy[i] = out_ready | ((vld_p & mask) != mask);
    end
  end

  // Upstream view of each stage: in_data for stage 0, the previous stage
  // otherwise.
  always_comb begin
    up_vld     = '0;
    up_vld[0]  = in_valid;
    up_data[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_vld[i]  = vld_p[i-1];
      up_data[i] = data_p[i-1];
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = vld_p[DEPTH-1];
  assign out_data  = data_p[DEPTH-1];
  assign count     = cnt_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Pipeline stage registers: valid bits and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      vld_p <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) vld_p[i] <= up_vld[i];
      end
      case ({in_xfer, out_xfer})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Pipeline stage registers: data. A bubble moving in never overwrites the
  // word a stage already holds, and flush leaves the data alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) data_p[i] <= RESET_VAL;
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i] && up_vld[i]) data_p[i] <= up_data[i];
      end
    end
  end

endmodule

// File: doc/flop_pipe.md
Name: flop_pipe

Overview:
- Parametrised successor to the single async-reset D flop: a DEPTH-stage, WIDTH-bit elastic register pipeline with per-stage valid bits, valid/ready backpressure, synchronous flush and an occupancy count.
- Used wherever a datapath needs registered delay or retiming with flow control, such as between processing blocks and before the output interface.
- All state is cleared by the asynchronous reset.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 3, number of register stages (>=1)
RESET_VAL, 0, value loaded into every data register on reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-low (0 = reset asserted)
in_valid  input  1  upstream presents in_data
in_ready  output  1  pipe accepts in_data this cycle
in_data  input  WIDTH  input word
out_valid  output  1  last stage holds a valid word
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  last-stage data register (driven unconditionally)
flush  input  1  synchronous clear of all valid bits
count  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - all stage valid bits = 0 and all data registers = RESET_VAL.
  - Outputs: out_valid=0, out_data=RESET_VAL, count=0, in_ready=1.
  - On deassertion, operation resumes at the next rising edge.
- Stage model: stage 0 is the input side and stage DEPTH-1 the output side. Each stage has v[i] and d[i].
- Ready chain (combinational):
  - r[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - r[i] = ~v[i] | r[i+1].
  - in_ready = r[0] & ~flush.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Stage i loads from stage i-1 (or from in_data when i=0) when r[i]=1. v[i] takes the upstream valid.
  - d[i] is written only when the upstream valid=1. A bubble never overwrites held data.
- Latency and throughput:
  - With no backpressure, a word accepted at edge N appears with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles from presentation to output.
  - Throughput is 1 word per cycle under continuous in_valid and out_ready.
- Backpressure:
  - With out_ready=0 the pipe fills bubble-free. Bubbles between words are squeezed out.
  - When all DEPTH stages are valid and out_ready=0, in_ready=0.
  - When full and out_ready=1, in_ready=1 in the same cycle (simultaneous in/out transfer) and count is unchanged.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold stable (AXI-style rule). in_valid dropping never affects held words.
- Flush:
  - flush=1 at an edge clears every v[i] to 0. Data registers are unchanged.
  - in_ready=0 during the flush cycle, so a coincident input is not accepted.
  - An output transfer in the flush cycle still completes from the downstream view (out_valid was 1 before the edge).
  - After flush: count=0, out_valid=0.
- count:
  - Registered. Updated each edge to +1 on input-only transfer, -1 on output-only transfer, unchanged on both or neither, 0 on flush.
  - count must always equal the popcount of v[].
- Reset mid-operation: all in-flight words are discarded immediately and asynchronously. There are no partial transfers.
- DEPTH=1 is a single registered slice with the same rules (full-throughput through the combinational ready path).

Test Plan:
1. Reset then stream: WIDTH=8, DEPTH=3, reset=0 then 1, out_ready=1, in_data=0x11,0x22,0x33,0x44 on consecutive cycles -> out_data 0x11..0x44 with out_valid=1 on 4 consecutive cycles, first valid 3 cycles after 0x11 presented; count peaks at 3.
2. Backpressure fill: out_ready=0, push 0xA1,0xA2,0xA3,0xA4 -> first 3 accepted, in_ready=0 while 0xA4 held, count=3, out_data=0xA1 stable. Raise out_ready -> 0xA1..0xA4 drain in order, no loss or duplication.
3. Bubbles: in_valid pattern 1,0,1,0,1 with data 0x05,-,0x06,-,0x07 and out_ready=0 -> count=3 and stages hold 0x05/0x06/0x07 compacted. Releasing out_ready yields 0x05,0x06,0x07 back-to-back.
4. Flush: pipe holding 3 words, assert flush with in_valid=1 and in_data=0xEE for one cycle -> in_ready=0 that cycle, next cycle count=0 and out_valid=0, 0xEE never emerges. Next word 0x10 passes normally.
5. Async reset mid-stream: while full and streaming, pull reset low between clock edges -> out_valid=0, count=0, out_data=RESET_VAL immediately with no clock edge. After release, a new stream starts cleanly.
6. Random soak: DEPTH=1 and DEPTH=5, randomised in_valid/out_ready/flush against a scoreboard queue model -> zero mismatches, count == popcount(v) every cycle, output stable under stall.
